charge_meter: RTL and testbench

Measurement stage directly downstream of the secant current controller. It takes the controller's current reference, loads it into the current DAC, waits for settling, and averages 2**LOG2_AVG ADC conversions of the integrated charge. It then returns a BUS_WIDTH-bit q_measured value with a one-cycle ready pulse, which is the controller's ready/q_measured input. The block free-runs while enabled, so each controller step gets a fresh measurement.

---
 rtl/charge_meter.sv | 147 ++++++++++++++
 tb/tb_charge_meter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/charge_meter.sv
// Charge measurement stage: loads the controller's current reference into the DAC,
// waits for settling, then averages 2**LOG2_AVG ADC conversions into a q_measured sample.
module charge_meter #(
    parameter int BUS_WIDTH     = 10,
    parameter int ADC_WIDTH     = 12,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOG2_AVG      = 2,
    parameter int ADC_TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] i_ref,
    output logic [BUS_WIDTH-1:0] dac_code,
    output logic                 dac_load,
    output logic                 adc_start,
    input  logic                 adc_done,
    input  logic [ADC_WIDTH-1:0] adc_data,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 adc_timeout
);

    localparam int ACC_W   = ADC_WIDTH + LOG2_AVG;
    localparam int CNT_W   = LOG2_AVG + 1;
    localparam int TMR_MAX = (SETTLE_CYCLES > ADC_TIMEOUT) ? SETTLE_CYCLES : ADC_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] NUM_AVG     = CNT_W'(2 ** LOG2_AVG);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST     = TMR_W'(ADC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, LATCH, SETTLE, CONVERT, WAIT_ADC, REPORT
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [BUS_WIDTH-1:0] dac_code_q, dac_code_d;
    logic [BUS_WIDTH-1:0] q_meas_q, q_meas_d;
    logic                 dac_load_q, dac_load_d;
    logic                 adc_start_q, adc_start_d;
    logic                 ready_q, ready_d;
    logic                 timeout_q, timeout_d;

    // Average and rescale to the bus: the top BUS_WIDTH bits of the sum, truncated.
    function automatic logic [BUS_WIDTH-1:0] scale_acc(input logic [ACC_W-1:0] a);
        return a[ACC_W-1 -: BUS_WIDTH];
    endfunction

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        dac_code_d  = dac_code_q;
        q_meas_d    = q_meas_q;
        timeout_d   = timeout_q;
        dac_load_d  = 1'b0;
        adc_start_d = 1'b0;
        ready_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!enable)         timeout_d = 1'b0;
                else if (!timeout_q) state_d   = LATCH;
            end
            LATCH: begin
                acc_d   = '0;
                cnt_d   = '0;
                tmr_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (tmr_q == SETTLE_LAST) state_d = CONVERT;
                else                      tmr_d   = tmr_q + TMR_W'(1);
            end
            CONVERT: begin
                tmr_d   = '0;
                state_d = WAIT_ADC;
            end
            WAIT_ADC: begin
                if (adc_done) begin
                    acc_d   = acc_q + ACC_W'(adc_data);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_d == NUM_AVG) ? REPORT : CONVERT;
                end else if (tmr_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            REPORT:  state_d = enable ? LATCH : IDLE;
            default: state_d = IDLE;
        endcase

        // Dropping enable mid-measurement abandons it outright.
        if (state_q != IDLE && !enable) begin
            state_d   = IDLE;
            timeout_d = timeout_q;
        end

        // Outputs are registered from the state being entered so they align with it.
        dac_load_d  = (state_d == LATCH);
        adc_start_d = (state_d == CONVERT);
        ready_d     = (state_d == REPORT);
        if (state_d == LATCH)  dac_code_d = i_ref;
        if (state_d == REPORT) q_meas_d   = scale_acc(acc_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            dac_code_q  <= '0;
            q_meas_q    <= '0;
            dac_load_q  <= 1'b0;
            adc_start_q <= 1'b0;
            ready_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            dac_code_q  <= dac_code_d;
            q_meas_q    <= q_meas_d;
            dac_load_q  <= dac_load_d;
            adc_start_q <= adc_start_d;
            ready_q     <= ready_d;
            timeout_q   <= timeout_d;
        end
    end

    assign dac_code    = dac_code_q;
    assign dac_load    = dac_load_q;
    assign adc_start   = adc_start_q;
    assign q_measured  = q_meas_q;
    assign ready       = ready_q;
    assign adc_timeout = timeout_q;

endmodule

// File: tb/tb_charge_meter.sv
// Directed bench for charge_meter: nominal timing, full-scale, i_ref hold, timeout, abort, async reset.
module tb_charge_meter;

    localparam int BW = 10;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst, enable, adc_done;
    logic [BW-1:0] i_ref, dac_code, q_measured;
    logic [AW-1:0] adc_data;
    logic          dac_load, adc_start, ready, adc_timeout;

    int tests = 0;
    int fails = 0;
    int samples[$];
    bit auto_rsp;
    bit pend;

    charge_meter #(
        .BUS_WIDTH(BW), .ADC_WIDTH(AW), .SETTLE_CYCLES(4), .LOG2_AVG(2), .ADC_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .i_ref(i_ref),
        .dac_code(dac_code), .dac_load(dac_load), .adc_start(adc_start),
        .adc_done(adc_done), .adc_data(adc_data), .q_measured(q_measured),
        .ready(ready), .adc_timeout(adc_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; answers each adc_start with adc_done one cycle later when auto_rsp is set.
    task automatic tick();
        @(posedge clk);
        #1;
        adc_done = 1'b0;
        if (pend) begin
            adc_done = 1'b1;
            adc_data = AW'(samples.pop_front());
            pend     = 1'b0;
        end
        if (adc_start && auto_rsp) pend = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!ready && n < 60);
        chk("ready_seen", 32'(ready), 32'd1);
    endtask

    task automatic wait_start();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!adc_start && n < 40);
        chk("start_seen", 32'(adc_start), 32'd1);
    endtask

    initial begin
        bit any_rdy, any_act;
        rst = 1'b1; enable = 1'b0; i_ref = '0; adc_done = 1'b0; adc_data = '0;
        auto_rsp = 1'b1; pend = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_dac_code", 32'(dac_code), 32'd0);
        chk("rst_dac_load", 32'(dac_load), 32'd0);
        chk("rst_adc_start", 32'(adc_start), 32'd0);
        chk("rst_q", 32'(q_measured), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_timeout", 32'(adc_timeout), 32'd0);

        // Nominal: LATCH at T0, starts at T5/7/9/11, ready at T13, next LATCH at T14
        samples = '{400, 404, 408, 412};
        i_ref = 10'd300; enable = 1'b1;
        tick();
        chk("t0_dac_load", 32'(dac_load), 32'd1);
        chk("t0_dac_code", 32'(dac_code), 32'd300);
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (t == 2) i_ref = 10'd500;
            chk($sformatf("nom_start_t%0d", t), 32'(adc_start),
                32'((t == 5) || (t == 7) || (t == 9) || (t == 11)));
            chk($sformatf("nom_ready_t%0d", t), 32'(ready), 32'(t == 13));
            chk($sformatf("nom_load_t%0d", t), 32'(dac_load), 32'(t == 14));
            if (t == 13) begin
                chk("nom_q", 32'(q_measured), 32'd101);
                chk("nom_code_held", 32'(dac_code), 32'd300);
            end
        end
        chk("relatch_code", 32'(dac_code), 32'd500);

        // Zero and full-scale measurements
        samples = '{0, 0, 0, 0};
        wait_ready();
        chk("zero_q", 32'(q_measured), 32'd0);
        chk("zero_code", 32'(dac_code), 32'd500);
        samples = '{4095, 4095, 4095, 4095};
        wait_ready();
        chk("full_q", 32'(q_measured), 32'd1023);

        // Timeout: no adc_done after the next adc_start
        auto_rsp = 1'b0;
        wait_start();
        any_rdy = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            any_rdy |= ready;
            if (k == 7) chk("to_not_yet", 32'(adc_timeout), 32'd0);
        end
        chk("to_flag", 32'(adc_timeout), 32'd1);
        chk("to_no_ready", 32'(any_rdy), 32'd0);
        chk("to_q_kept", 32'(q_measured), 32'd1023);
        any_act = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            any_act |= dac_load | adc_start | ready;
        end
        chk("to_stays_idle", 32'(any_act), 32'd0);
        chk("to_sticky", 32'(adc_timeout), 32'd1);
        enable = 1'b0;
        tick();
        chk("to_cleared", 32'(adc_timeout), 32'd0);
        enable = 1'b1;
        tick();
        chk("to_restart_load", 32'(dac_load), 32'd1);
        chk("to_restart_code", 32'(dac_code), 32'd500);

        // Abort during WAIT_ADC, then a stray adc_done
        wait_start();
        tick();
        enable = 1'b0;
        tick();
        adc_done = 1'b1; adc_data = 12'd2000;
        any_act = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            any_act |= dac_load | adc_start | ready;
        end
        chk("abort_quiet", 32'(any_act), 32'd0);
        chk("abort_q_kept", 32'(q_measured), 32'd1023);
        chk("abort_no_to", 32'(adc_timeout), 32'd0);

        // Asynchronous reset mid-SETTLE
        i_ref = 10'h155; enable = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_code", 32'(dac_code), 32'h155);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_code", 32'(dac_code), 32'd0);
        chk("arst_q", 32'(q_measured), 32'd0);
        chk("arst_outs", 32'({dac_load, adc_start, ready, adc_timeout}), 32'd0);
        tick();
        enable = 1'b0;
        rst = 1'b0;
        any_act = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            any_act |= dac_load | adc_start | ready;
        end
        chk("post_rst_idle", 32'(any_act), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
